// File: rtl/vga_draw_rect_if.sv
// Bundle of request, load and pixel-output signals between a controller and the rectangle rasteriser.
// dbg_state mirrors the rasteriser FSM for observation only.
interface vga_draw_rect_if #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3
);
   // Requests are levels whose rising edge is the event. They are honoured only while
   // the rasteriser is idle (busy=0, done=0); edges seen at any other time are dropped.
   logic [X_W-1:0]      pos_in;
   logic                store_pos;
   logic [COLOUR_W-1:0] color_in;
   logic                outline;
   logic                plot;
   logic                clear_scr;
   logic                plot_enable;
   logic [X_W-1:0]      X;
   logic [Y_W-1:0]      Y;
   logic [COLOUR_W-1:0] color_out;
   logic                busy;
   logic                done;
   logic [1:0]          dbg_state;

   modport master (
      output pos_in, store_pos, color_in, outline, plot, clear_scr,
      input  plot_enable, X, Y, color_out, busy, done, dbg_state
   );

   modport slave (
      input  pos_in, store_pos, color_in, outline, plot, clear_scr,
      output plot_enable, X, Y, color_out, busy, done, dbg_state
   );
endinterface

// File: rtl/vga_draw_rect.sv
// Rectangle rasteriser: loads X/Y/W/H from a shared bus, then emits one pixel per clock
// (filled or outline, clipped at the screen edge), or clears the whole screen to colour 0.
module vga_draw_rect #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int SIZE_W   = 5,
   parameter int COLOUR_W = 3,
   parameter int SCR_W    = 160,
   parameter int SCR_H    = 120
) (
   input  logic           clock,
   input  logic           resetn,
   vga_draw_rect_if.slave bus
);
   localparam int CX_W = (X_W > SIZE_W) ? X_W : SIZE_W;
   localparam int CY_W = (Y_W > SIZE_W) ? Y_W : SIZE_W;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAW = 2'd1, S_CLEAR = 2'd2, S_DONE = 2'd3} state_t;
   typedef enum logic [1:0] {SLOT_X = 2'd0, SLOT_Y = 2'd1, SLOT_W = 2'd2, SLOT_H = 2'd3} slot_t;

   state_t              state_q, state_d;
   slot_t               slot_q, slot_d;
   logic                loaded_q, loaded_d;
   logic [X_W-1:0]      x0_q, x0_d;
   logic [Y_W-1:0]      y0_q, y0_d;
   logic [SIZE_W-1:0]   w_q, w_d;
   logic [SIZE_W-1:0]   h_q, h_d;
   logic                outl_q, outl_d;
   logic [CX_W-1:0]     cx_q, cx_d;
   logic [CY_W-1:0]     cy_q, cy_d;
   logic                store_prev_q, plot_prev_q, clr_prev_q;
   logic                pe_q, pe_d;
   logic [X_W-1:0]      xo_q, xo_d;
   logic [Y_W-1:0]      yo_q, yo_d;
   logic [COLOUR_W-1:0] co_q, co_d;

   logic                store_edge, plot_edge, clr_edge;
   logic [CX_W-1:0]     w_last;
   logic [CY_W-1:0]     h_last;
   logic                pix_en, pix_outl, on_border;
   logic [X_W:0]        sum_x;
   logic [Y_W:0]        sum_y;

   assign store_edge = bus.store_pos & ~store_prev_q;
   assign plot_edge  = bus.plot & ~plot_prev_q;
   assign clr_edge   = bus.clear_scr & ~clr_prev_q;
   assign w_last     = CX_W'(w_q) - CX_W'(1);
   assign h_last     = CY_W'(h_q) - CY_W'(1);

   // The counters always hold the position currently on the outputs; each cycle the
   // next position is computed here and its pixel is registered straight into the outputs.
   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      loaded_d = loaded_q;
      x0_d     = x0_q;
      y0_d     = y0_q;
      w_d      = w_q;
      h_d      = h_q;
      outl_d   = outl_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      pe_d     = 1'b0;
      xo_d     = xo_q;
      yo_d     = yo_q;
      co_d     = co_q;
      pix_en   = 1'b0;
      pix_outl = outl_q;
      case (state_q)
         S_IDLE: begin
            if (store_edge) begin
               case (slot_q)
                  SLOT_X: begin x0_d = bus.pos_in;              slot_d = SLOT_Y; end
                  SLOT_Y: begin y0_d = bus.pos_in[Y_W-1:0];     slot_d = SLOT_W; end
                  SLOT_W: begin w_d  = bus.pos_in[SIZE_W-1:0];  slot_d = SLOT_H; end
                  SLOT_H: begin h_d  = bus.pos_in[SIZE_W-1:0];  slot_d = SLOT_X; loaded_d = 1'b1; end
               endcase
            end
            if (clr_edge) begin
               state_d = S_CLEAR;
               cx_d    = '0;
               cy_d    = '0;
               pe_d    = 1'b1;
               xo_d    = '0;
               yo_d    = '0;
               co_d    = '0;
            end else if (plot_edge && loaded_q) begin
               outl_d = bus.outline;
               co_d   = bus.color_in;
               if (w_d == '0 || h_d == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d  = S_DRAW;
                  cx_d     = '0;
                  cy_d     = '0;
                  pix_en   = 1'b1;
                  pix_outl = bus.outline;
               end
            end
         end
         S_DRAW: begin
            if (cx_q == w_last && cy_q == h_last) begin
               state_d = S_DONE;
            end else begin
               if (cx_q == w_last) begin
                  cx_d = '0;
                  cy_d = cy_q + CY_W'(1);
               end else begin
                  cx_d = cx_q + CX_W'(1);
               end
               pix_en = 1'b1;
            end
         end
         S_CLEAR: begin
            if (cx_q == CX_W'(SCR_W - 1) && cy_q == CY_W'(SCR_H - 1)) begin
               state_d = S_DONE;
            end else begin
               if (cx_q == CX_W'(SCR_W - 1)) begin
                  cx_d = '0;
                  cy_d = cy_q + CY_W'(1);
               end else begin
                  cx_d = cx_q + CX_W'(1);
               end
               pe_d = 1'b1;
               xo_d = X_W'(cx_d);
               yo_d = Y_W'(cy_d);
            end
         end
         S_DONE: state_d = S_IDLE;
      endcase

      // Sums carry one extra bit so an overflowing coordinate is clipped instead of wrapping.
      sum_x     = (X_W + 1)'(x0_d) + (X_W + 1)'(cx_d);
      sum_y     = (Y_W + 1)'(y0_d) + (Y_W + 1)'(cy_d);
      on_border = (cx_d == '0) || (cx_d == w_last) || (cy_d == '0) || (cy_d == h_last);
      if (pix_en) begin
         pe_d = (sum_x < (X_W + 1)'(SCR_W)) && (sum_y < (Y_W + 1)'(SCR_H)) && (!pix_outl || on_border);
         xo_d = sum_x[X_W-1:0];
         yo_d = sum_y[Y_W-1:0];
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         slot_q       <= SLOT_X;
         loaded_q     <= 1'b0;
         x0_q         <= '0;
         y0_q         <= '0;
         w_q          <= '0;
         h_q          <= '0;
         outl_q       <= 1'b0;
         cx_q         <= '0;
         cy_q         <= '0;
         store_prev_q <= 1'b0;
         plot_prev_q  <= 1'b0;
         clr_prev_q   <= 1'b0;
         pe_q         <= 1'b0;
         xo_q         <= '0;
         yo_q         <= '0;
         co_q         <= '0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         loaded_q     <= loaded_d;
         x0_q         <= x0_d;
         y0_q         <= y0_d;
         w_q          <= w_d;
         h_q          <= h_d;
         outl_q       <= outl_d;
         cx_q         <= cx_d;
         cy_q         <= cy_d;
         store_prev_q <= bus.store_pos;
         plot_prev_q  <= bus.plot;
         clr_prev_q   <= bus.clear_scr;
         pe_q         <= pe_d;
         xo_q         <= xo_d;
         yo_q         <= yo_d;
         co_q         <= co_d;
      end
   end

   assign bus.plot_enable = pe_q;
   assign bus.X           = xo_q;
   assign bus.Y           = yo_q;
   assign bus.color_out   = co_q;
   assign bus.busy        = (state_q == S_DRAW) || (state_q == S_CLEAR);
   assign bus.done        = (state_q == S_DONE);
   assign bus.dbg_state   = state_q;
endmodule
